full_add: RTL and testbench

FULL_ADD -- requirements
Module: full_add

---
 rtl/full_add_pkg.sv | 15 +
 rtl/half_add.sv | 15 +
 rtl/full_add.sv | 89 ++++++++
 tb/tb_full_add.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/full_add_pkg.sv
// Shared constants and types for the full adder.
//   REGISTER_OUT_DEF : default for registered (1) vs combinational (0) s/co
//   SERIAL_EN_DEF    : default for availability of bit-serial carry feedback
//   fa_res_t         : packed 2-bit adder result {co, s}
package full_add_pkg;

  localparam bit REGISTER_OUT_DEF = 1'b1;
  localparam bit SERIAL_EN_DEF    = 1'b1;

  typedef struct packed {
    logic co;
    logic s;
  } fa_res_t;

endpackage : full_add_pkg

// File: rtl/half_add.sv
// Half adder building block.
//   a, b  : operand bits
//   sum   : a XOR b
//   carry : a AND b
module half_add (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule : half_add

// File: rtl/full_add.sv
// One-bit full adder with optional output register and bit-serial carry
// feedback. In serial mode the stored carry replaces ci, so a multi-bit word
// can be added LSB first, one bit per clock.
//   clk         : rising-edge clock for all state
//   rst         : synchronous active-high reset
//   a, b        : addend bits
//   ci          : carry-in bit (used when not in serial mode)
//   serial_mode : 1 = use stored carry instead of ci
//   s, co       : sum and carry-out (registered or combinational)
//   carry_q     : stored serial carry
module full_add
  import full_add_pkg::*;
#(
  parameter bit REGISTER_OUT = REGISTER_OUT_DEF,
  parameter bit SERIAL_EN    = SERIAL_EN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic ci,
  input  logic serial_mode,
  output logic s,
  output logic co,
  output logic carry_q
);

  logic    w_serial;
  logic    w_cin_eff;
  logic    w_sum1;
  logic    w_carry1;
  logic    w_carry2;
  fa_res_t w_res;
  logic    r_carry;

  // Serial mode is forced off when the feature is not built in.
  assign w_serial  = serial_mode & SERIAL_EN;
  assign w_cin_eff = w_serial ? r_carry : ci;

  half_add u_ha0 (
    .a     (a),
    .b     (b),
    .sum   (w_sum1),
    .carry (w_carry1)
  );

  half_add u_ha1 (
    .a     (w_sum1),
    .b     (w_cin_eff),
    .sum   (w_res.s),
    .carry (w_carry2)
  );

  assign w_res.co = w_carry1 | w_carry2;

  // Stored carry clears whenever serial mode drops so each word starts fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_carry <= 1'b0;
    end else if (w_serial) begin
      r_carry <= w_res.co;
    end else begin
      r_carry <= 1'b0;
    end
  end

  assign carry_q = r_carry;

  generate
    if (REGISTER_OUT) begin : g_reg_out
      fa_res_t r_res;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_res <= '0;
        end else begin
          r_res <= w_res;
        end
      end

      assign s  = r_res.s;
      assign co = r_res.co;
    end else begin : g_comb_out
      assign s  = w_res.s;
      assign co = w_res.co;
    end
  endgenerate

endmodule : full_add

// File: tb/tb_full_add.sv
// Self-checking bench for full_add: one registered and one combinational
// instance share the same stimulus and are compared against an arithmetic
// reference model plus fixed truth-table and serial-word expectations.
module tb_full_add;

  logic clk;
  logic rst;
  logic a;
  logic b;
  logic ci;
  logic serial_mode;
  logic s_r, co_r, cq_r;
  logic s_c, co_c, cq_c;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: stored carry and registered result.
  logic m_carry;
  logic m_s;
  logic m_co;

  typedef struct {
    logic a;
    logic b;
    logic ci;
    logic s;
    logic co;
  } vec_t;

  vec_t tbl[8];

  full_add #(.REGISTER_OUT(1'b1), .SERIAL_EN(1'b1)) u_dut_reg (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .b           (b),
    .ci          (ci),
    .serial_mode (serial_mode),
    .s           (s_r),
    .co          (co_r),
    .carry_q     (cq_r)
  );

  full_add #(.REGISTER_OUT(1'b0), .SERIAL_EN(1'b1)) u_dut_comb (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .b           (b),
    .ci          (ci),
    .serial_mode (serial_mode),
    .s           (s_c),
    .co          (co_c),
    .carry_q     (cq_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // One clock of stimulus: check the combinational instance before the edge,
  // advance the model on the edge, then check registered outputs and carries.
  task automatic cyc(input logic ia, input logic ib, input logic ici,
                     input logic ism, input logic irst,
                     output logic os_c, output logic oco_c);
    logic       cin;
    logic [1:0] tot;
    a = ia; b = ib; ci = ici; serial_mode = ism; rst = irst;
    #1;
    cin = ism ? m_carry : ici;
    tot = 2'(ia) + 2'(ib) + 2'(cin);
    os_c  = s_c;
    oco_c = co_c;
    chk("comb_s", s_c, tot[0]);
    chk("comb_co", co_c, tot[1]);
    @(posedge clk);
    if (irst) begin
      m_s = 1'b0; m_co = 1'b0; m_carry = 1'b0;
    end else begin
      m_s = tot[0]; m_co = tot[1];
      m_carry = ism ? tot[1] : 1'b0;
    end
    #1;
    chk("reg_s", s_r, m_s);
    chk("reg_co", co_r, m_co);
    chk("reg_carry_q", cq_r, m_carry);
    chk("comb_carry_q", cq_c, m_carry);
  endtask

  initial begin
    logic       xs, xc;
    logic [3:0] wa, wb, es;

    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    m_carry = 1'b0; m_s = 1'b0; m_co = 1'b0;
    a = 1'b1; b = 1'b1; ci = 1'b1; serial_mode = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_s", s_r, 1'b0);
    chk("rst_co", co_r, 1'b0);
    chk("rst_carry_q", cq_r, 1'b0);
    chk("rst_comb_carry_q", cq_c, 1'b0);

    // Truth-table sweep, non-serial.
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].a, tbl[i].b, tbl[i].ci, 1'b0, 1'b0, xs, xc);
      chk("sweep_comb_s", xs, tbl[i].s);
      chk("sweep_comb_co", xc, tbl[i].co);
      chk("sweep_reg_s", s_r, tbl[i].s);
      chk("sweep_reg_co", co_r, tbl[i].co);
    end

    // 0111 + 0011 serial, expecting 1010 with no final carry.
    wa = 4'b0111; wb = 4'b0011; es = 4'b1010;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, xs, xc);
    for (int i = 0; i < 4; i++) begin
      cyc(wa[i], wb[i], 1'b0, 1'b1, 1'b0, xs, xc);
      chk("ser_0111_0011_s", s_r, es[i]);
    end
    chk("ser_0111_0011_carry_q", cq_r, 1'b0);

    // Same word, reset pulsed on bit 2 discards the carry.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, xs, xc);
    cyc(wa[0], wb[0], 1'b0, 1'b1, 1'b0, xs, xc);
    cyc(wa[1], wb[1], 1'b0, 1'b1, 1'b0, xs, xc);
    chk("ser_mid_carry_before_rst", cq_r, 1'b1);
    cyc(wa[2], wb[2], 1'b0, 1'b1, 1'b1, xs, xc);
    chk("ser_rst_s", s_r, 1'b0);
    chk("ser_rst_co", co_r, 1'b0);
    chk("ser_rst_carry_q", cq_r, 1'b0);
    chk("ser_rst_comb_carry_q", cq_c, 1'b0);

    // 1111 + 0001 serial: all-zero sum, carry out of the last bit.
    wa = 4'b1111; wb = 4'b0001;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, xs, xc);
    for (int i = 0; i < 4; i++) begin
      cyc(wa[i], wb[i], 1'b0, 1'b1, 1'b0, xs, xc);
      chk("ser_1111_0001_s", s_r, 1'b0);
    end
    chk("ser_1111_0001_co", co_r, 1'b1);
    chk("ser_1111_0001_carry_q", cq_r, 1'b1);

    // Dropping serial_mode uses ci and ignores the stored carry.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, xs, xc);
    chk("nonser_comb_s", xs, 1'b1);
    chk("nonser_comb_co", xc, 1'b0);
    chk("nonser_s", s_r, 1'b1);
    chk("nonser_co", co_r, 1'b0);
    chk("nonser_carry_q", cq_r, 1'b0);

    // Randomized traffic against the arithmetic model.
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
          xs, xc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_full_add
